// File: rtl/poly_seq_pkg.sv
// Shared types for the polynomial datapath sequencer: state encoding and the per-state control table.
package poly_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDX  = 3'd1,
        ST2  = 3'd2,
        ST3  = 3'd3,
        ST4  = 3'd4,
        ST5  = 3'd5,
        ST6  = 3'd6,
        DONE = 3'd7
    } state_t;

    typedef struct packed {
        logic       h;
        logic       lx;
        logic       lh;
        logic       ls;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
    } ctrl_t;

    // Field order: h, lx, lh, ls, m0, m1, m2; row index is the state encoding.
    localparam ctrl_t CTRL_TABLE [8] = '{
        '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0},
        '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0},
        '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd0},
        '{1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 2'd2},
        '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0},
        '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 2'd2},
        '{1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd3, 2'd1},
        '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0}
    };

endpackage

// File: rtl/poly_seq_arbiter_if.sv
// Requester/datapath control bundle for poly_seq_arbiter.
// The abort input exists only when POLY_SEQ_ABORT_EN is defined.
interface poly_seq_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0] req;
    logic            stall;
`ifdef POLY_SEQ_ABORT_EN
    logic            abort;
`endif
    logic [NREQ-1:0] gnt;
    logic            h;
    logic            lx;
    logic            lh;
    logic            ls;
    logic [1:0]      m0;
    logic [1:0]      m1;
    logic [1:0]      m2;
    logic            ready;
    logic            done;

`ifdef POLY_SEQ_ABORT_EN
    modport master (output req, stall, abort,
                    input  gnt, h, lx, lh, ls, m0, m1, m2, ready, done);
    modport slave  (input  req, stall, abort,
                    output gnt, h, lx, lh, ls, m0, m1, m2, ready, done);
`else
    modport master (output req, stall,
                    input  gnt, h, lx, lh, ls, m0, m1, m2, ready, done);
    modport slave  (input  req, stall,
                    output gnt, h, lx, lh, ls, m0, m1, m2, ready, done);
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr, wrapping to the bottom.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_next,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    // First pass covers indices >= ptr, second pass the wrapped indices below ptr.
    always_comb begin
        gnt_next = '0;
        idx      = '0;
        valid    = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!valid && req[j] && (IW'(j) >= ptr)) begin
                valid       = 1'b1;
                idx         = IW'(j);
                gnt_next[j] = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!valid && req[j] && (IW'(j) < ptr)) begin
                valid       = 1'b1;
                idx         = IW'(j);
                gnt_next[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/poly_seq_arbiter.sv
// Round-robin arbiter and 8-state sequencer driving the shared polynomial datapath controls.
// Optional feature macro: POLY_SEQ_ABORT_EN adds an abort input that returns the sequencer to IDLE.
module poly_seq_arbiter
    import poly_seq_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    poly_seq_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] arb_gnt;
    logic            arb_valid;
    logic            abort_req;
    logic            done_c;
    ctrl_t           ctrl;

`ifdef POLY_SEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req      (bus.req),
        .ptr      (ptr_q),
        .gnt_next (arb_gnt),
        .idx      (arb_idx),
        .valid    (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (arb_valid) begin
                state_d = LDX;
            end
        end else if (abort_req) begin
            state_d = IDLE;
        end else if (!bus.stall) begin
            state_d = (state_q == DONE) ? IDLE : state_t'(state_q + 3'd1);
        end
    end

    // The pointer only advances on a completed operation, so an aborted owner keeps its priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
            idx_q <= '0;
            ptr_q <= '0;
        end else if (state_q == IDLE) begin
            if (arb_valid) begin
                gnt_q <= arb_gnt;
                idx_q <= arb_idx;
            end
        end else if (abort_req) begin
            gnt_q <= '0;
        end else if ((state_q == DONE) && !bus.stall) begin
            gnt_q <= '0;
            ptr_q <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        ctrl   = CTRL_TABLE[state_q];
        done_c = (state_q == DONE) && !abort_req;
        if ((state_q != IDLE) && bus.stall) begin
            ctrl.lx = 1'b0;
            ctrl.lh = 1'b0;
            ctrl.ls = 1'b0;
            done_c  = 1'b0;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.h     = ctrl.h;
    assign bus.lx    = ctrl.lx;
    assign bus.lh    = ctrl.lh;
    assign bus.ls    = ctrl.ls;
    assign bus.m0    = ctrl.m0;
    assign bus.m1    = ctrl.m1;
    assign bus.m2    = ctrl.m2;
    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_c;

endmodule
